// File: rtl/pipe_decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard output and ID/EX register outputs.
// master = upstream/environment side, slave = the decode stage itself.
interface pipe_decode_stage_if #(
    parameter int unsigned DATA_W = 16
);
    logic              if_valid;
    logic [15:0]       instruction;
    logic [15:0]       pc_in;
    logic [15:0]       next_pc_in;
    logic              flush;
    logic              wb_en;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              stall_out;
    logic              ex_valid;
    logic [15:0]       ex_pc;
    logic [15:0]       ex_next_pc;
    logic [DATA_W-1:0] ex_srca;
    logic [DATA_W-1:0] ex_srcb;
    logic [DATA_W-1:0] ex_imm8;
    logic [DATA_W-1:0] ex_imm11;
    logic [1:0]        ex_func;
    logic [13:0]       ex_ctrl;
    logic [2:0]        ex_wreg;
    logic              ex_wen;
    logic              err;

    modport master (
        output if_valid, instruction, pc_in, next_pc_in, flush, wb_en, wb_reg, wb_data,
        input  stall_out, ex_valid, ex_pc, ex_next_pc, ex_srca, ex_srcb, ex_imm8, ex_imm11,
               ex_func, ex_ctrl, ex_wreg, ex_wen, err
    );

    modport slave (
        input  if_valid, instruction, pc_in, next_pc_in, flush, wb_en, wb_reg, wb_data,
        output stall_out, ex_valid, ex_pc, ex_next_pc, ex_srca, ex_srcb, ex_imm8, ex_imm11,
               ex_func, ex_ctrl, ex_wreg, ex_wen, err
    );
endinterface

// File: rtl/pipe_decode_stage.sv
// WISC decode stage: instruction decode, 8-entry register file with write-before-read bypass,
// operand/immediate formation, load-use hazard detection and the ID/EX pipeline register.
module pipe_decode_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          HAZARD_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    pipe_decode_stage_if.slave bus
);
    logic [4:0] opcode;
    logic [2:0] rs, rt;
    assign opcode = bus.instruction[15:11];
    assign rs     = bus.instruction[10:8];
    assign rt     = bus.instruction[7:5];

    // Decoded control
    logic [1:0] regsrc, regdst, bsource;
    logic       immsrc, memwrt, inva, invb, alujmp, regwrt, asource, ext, illegal;
    logic [2:0] branch;
    logic [3:0] aluopr;

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] rs_data, rt_data, srca, srcb, imm5, imm8, imm11;
    logic [2:0]        wreg;
    logic              stall;

    logic              ex_valid_q, ex_wen_q, ex_is_load_q, err_q;
    logic [15:0]       ex_pc_q, ex_next_pc_q;
    logic [DATA_W-1:0] ex_srca_q, ex_srcb_q, ex_imm8_q, ex_imm11_q;
    logic [1:0]        ex_func_q;
    logic [13:0]       ex_ctrl_q;
    logic [2:0]        ex_wreg_q;

    // Opcode decode; the two unassigned opcodes (00010, 00011) are flagged illegal
    always_comb begin
        regsrc  = 2'd0;
        immsrc  = 1'b0;
        memwrt  = 1'b0;
        inva    = 1'b0;
        invb    = 1'b0;
        branch  = 3'd0;
        alujmp  = 1'b0;
        aluopr  = 4'd0;
        regdst  = 2'd0;
        regwrt  = 1'b0;
        asource = 1'b0;
        bsource = 2'd0;
        ext     = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            5'b00000: branch = 3'd7;                                          // halt
            5'b00001: begin end                                               // nop
            5'b00100: begin branch = 3'd5; immsrc = 1'b1; bsource = 2'd3; end // j
            5'b00101: begin branch = 3'd6; alujmp = 1'b1; bsource = 2'd2; end // jr
            5'b00110: begin                                                   // jal
                branch = 3'd5; immsrc = 1'b1; bsource = 2'd3;
                regsrc = 2'd2; regdst = 2'd3; regwrt = 1'b1;
            end
            5'b00111: begin                                                   // jalr
                branch = 3'd6; alujmp = 1'b1; bsource = 2'd2;
                regsrc = 2'd2; regdst = 2'd3; regwrt = 1'b1;
            end
            5'b01000: begin regwrt = 1'b1; bsource = 2'd1; end                // addi
            5'b01001: begin regwrt = 1'b1; bsource = 2'd1; inva = 1'b1; end   // subi
            5'b01010: begin regwrt = 1'b1; bsource = 2'd1; ext = 1'b1; aluopr = 4'd1; end
            5'b01011: begin                                                   // andni
                regwrt = 1'b1; bsource = 2'd1; ext = 1'b1; invb = 1'b1; aluopr = 4'd2;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin                     // beqz..bgez
                bsource = 2'd2;
                branch  = 3'd1 + {1'b0, opcode[1:0]};
            end
            5'b10000: begin bsource = 2'd1; memwrt = 1'b1; end                // st
            5'b10001: begin regwrt = 1'b1; bsource = 2'd1; regsrc = 2'd1; end // ld
            5'b10010: begin                                                   // slbi
                regdst = 2'd1; regwrt = 1'b1; asource = 1'b1; bsource = 2'd2;
                ext = 1'b1; aluopr = 4'd13;
            end
            5'b10011: begin                                                   // stu
                regdst = 2'd1; regwrt = 1'b1; bsource = 2'd1; memwrt = 1'b1;
            end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin                     // roli..srli
                regwrt = 1'b1; bsource = 2'd1; ext = 1'b1;
                aluopr = 4'd3 + {2'b00, opcode[1:0]};
            end
            5'b11000: begin regdst = 2'd1; regwrt = 1'b1; bsource = 2'd2; aluopr = 4'd12; end
            5'b11001: begin regdst = 2'd2; regwrt = 1'b1; aluopr = 4'd11; end // btr
            5'b11010: begin regdst = 2'd2; regwrt = 1'b1; aluopr = 4'd15; end // shift, func
            5'b11011: begin regdst = 2'd2; regwrt = 1'b1; aluopr = 4'd14; end // arith, func
            5'b11100, 5'b11101, 5'b11110, 5'b11111: begin                     // seq..sco
                regdst = 2'd2; regwrt = 1'b1;
                aluopr = 4'd7 + {2'b00, opcode[1:0]};
            end
            default: illegal = 1'b1;
        endcase
    end

    // Register file write port, driven by writeback regardless of stall/flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (bus.wb_en) begin
            regs_q[bus.wb_reg] <= bus.wb_data;
        end
    end

    // Read ports with optional same-cycle writeback forwarding
    always_comb begin
        rs_data = regs_q[rs];
        rt_data = regs_q[rt];
        if (BYPASS && bus.wb_en && bus.wb_reg == rs) rs_data = bus.wb_data;
        if (BYPASS && bus.wb_en && bus.wb_reg == rt) rt_data = bus.wb_data;
    end

    // Immediates, operands and destination select
    always_comb begin
        imm5  = ext ? {{(DATA_W-5){1'b0}}, bus.instruction[4:0]}
                    : {{(DATA_W-5){bus.instruction[4]}}, bus.instruction[4:0]};
        imm8  = ext ? {{(DATA_W-8){1'b0}}, bus.instruction[7:0]}
                    : {{(DATA_W-8){bus.instruction[7]}}, bus.instruction[7:0]};
        imm11 = {{(DATA_W-11){bus.instruction[10]}}, bus.instruction[10:0]};
        srca  = asource ? (rs_data << 8) : rs_data;
        unique case (bsource)
            2'd0:    srcb = rt_data;
            2'd1:    srcb = imm5;
            2'd2:    srcb = imm8;
            default: srcb = imm11;
        endcase
        unique case (regdst)
            2'd0:    wreg = bus.instruction[7:5];
            2'd1:    wreg = bus.instruction[10:8];
            2'd2:    wreg = bus.instruction[4:2];
            default: wreg = 3'd7;
        endcase
    end

    // Load-use check compares both source fields even when one is unused
    assign stall = HAZARD_EN & ~rst & bus.if_valid & ex_valid_q & ex_is_load_q & ex_wen_q &
                   ((ex_wreg_q == rs) | (ex_wreg_q == rt)) & ~bus.flush;

    // ID/EX register: flush beats stall beats capture; data fields hold during bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_pc_q      <= '0;
            ex_next_pc_q <= '0;
            ex_srca_q    <= '0;
            ex_srcb_q    <= '0;
            ex_imm8_q    <= '0;
            ex_imm11_q   <= '0;
            ex_func_q    <= '0;
            ex_ctrl_q    <= '0;
            ex_wreg_q    <= '0;
        end else if (bus.flush || stall || !bus.if_valid) begin
            ex_valid_q   <= 1'b0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= 1'b1;
            ex_wen_q     <= regwrt;
            ex_is_load_q <= (opcode == 5'b10001);
            ex_pc_q      <= bus.pc_in;
            ex_next_pc_q <= bus.next_pc_in;
            ex_srca_q    <= srca;
            ex_srcb_q    <= srcb;
            ex_imm8_q    <= imm8;
            ex_imm11_q   <= imm11;
            ex_func_q    <= bus.instruction[1:0];
            ex_ctrl_q    <= {regsrc, immsrc, memwrt, inva, invb, branch, alujmp, aluopr};
            ex_wreg_q    <= wreg;
        end
    end

    // Error flag follows the current inputs each cycle (an X write index only shows in sim)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (bus.if_valid & illegal) | $isunknown(bus.wb_reg);
    end

    assign bus.stall_out  = stall;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_wen     = ex_wen_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_next_pc = ex_next_pc_q;
    assign bus.ex_srca    = ex_srca_q;
    assign bus.ex_srcb    = ex_srcb_q;
    assign bus.ex_imm8    = ex_imm8_q;
    assign bus.ex_imm11   = ex_imm11_q;
    assign bus.ex_func    = ex_func_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_wreg    = ex_wreg_q;
    assign bus.err        = err_q;
endmodule

// File: doc/pipe_decode_stage.md
Name: pipe_decode_stage

Overview:
- Parametrised, pipelined decode stage for the WISC-style core.
- Decodes a 16-bit instruction and reads the register file with write-before-read bypass.
- Forms the A/B operands and immediates, and detects load-use hazards.
- Captures everything in an ID/EX pipeline register with valid, stall and flush handling.
- Sits between the IF/ID register and the execute stage; writeback drives the register-file write port directly.

Parameters:
- DATA_W, 16: datapath/register width (>=16); immediates sign/zero-extend to DATA_W.
- BYPASS, 1: 1 = same-cycle writeback data forwarded to read ports; 0 = read returns old contents.
- HAZARD_EN, 1: 1 = load-use stall logic active; 0 = stall_out tied 0.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- if_valid  input  1  IF/ID holds a valid instruction
- instruction  input  16  instruction from IF/ID
- pc_in  input  16  PC of instruction
- next_pc_in  input  16  PC+2 of instruction
- flush  input  1  squash instruction in decode (branch resolved taken)
- wb_en  input  1  register-file write enable from WB
- wb_reg  input  3  write register index from WB
- wb_data  input  DATA_W  write data from WB
- stall_out  output  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  output  1  ID/EX contents valid
- ex_pc, ex_next_pc  output  16 each  registered PCs
- ex_srca, ex_srcb  output  DATA_W each  registered operands
- ex_imm8, ex_imm11  output  DATA_W each  registered 8-bit (ext-selected) and 11-bit (sign-extended) immediates
- ex_func  output  2  registered instruction[1:0]
- ex_ctrl  output  14  registered {regsrc, immsrc, memwrt, inva, invb, branch[2:0], alujmp, aluopr[3:0]}, MSB first
- ex_wreg  output  3  registered destination register
- ex_wen  output  1  registered register-write enable (0 when bubble)
- err  output  1  registered error: illegal opcode decoded while if_valid, or wb_reg X/out of range

Behaviour:
- Reset (async):
  - ex_valid, ex_wen, err = 0; every ex_* bus = 0.
  - All 8 registers = 0; stall_out = 0 while rst is high.
- Decode:
  - Control comes from instruction_decoder on instruction[15:11].
  - rs = instruction[10:8], rt = instruction[7:5].
  - Destination selected by regdst: 0 = [7:5], 1 = [10:8], 2 = [4:2], 3 = 3'd7.
- Register file:
  - 8 x DATA_W; write on rising edge when wb_en.
  - With BYPASS=1 and wb_en, wb_reg matching a read index returns wb_data in the same cycle.
- Operands:
  - srca = asource ? (rs_data << 8) : rs_data.
  - srcb per bsource: 0 = rt_data, 1 = imm5 (SE/ZE by ext), 2 = imm8 (SE/ZE by ext), 3 = SE imm11.
- Hazard (HAZARD_EN=1):
  - stall_out = if_valid & ex_valid & ex_is_load & ex_wen & (ex_wreg==rs | ex_wreg==rt) & ~flush.
  - ex_is_load is a registered bit, set when the opcode is 5'b10001.
  - The compare is conservative: both indices are checked regardless of use.
- ID/EX update each clock, highest priority first:
  - flush: ex_valid <= 0, ex_wen <= 0.
  - stall_out: bubble; ex_valid <= 0, ex_wen <= 0, ex_is_load <= 0. The upstream holds the instruction, so it re-decodes next cycle.
  - if_valid: capture all fields; ex_valid <= 1; ex_wen <= regwrt.
  - otherwise: ex_valid <= 0, ex_wen <= 0.
- Data busses in a bubble are don't-care but must not be X. Hold the previous value.
- Latency: 1 cycle from decode inputs to ex_* outputs. Load-use costs exactly 1 bubble.
- Register-file writes happen regardless of stall/flush.
- err updates every cycle from the current inputs; it is not sticky.
- Reset mid-stall: stall_out drops immediately; no state survives.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 → ex_valid=0, ex_srca=0 asynchronously; after release, reading r3 gives 0.
- Bypass: wb_en=1, wb_reg=2, wb_data=16'h1234, same cycle ADD r2,r2 → ex_srca=ex_srcb=16'h1234 next edge (BYPASS=1). BYPASS=0 → 0.
- Load-use: LD r1 into ID/EX, then ADD reading r1 → stall_out=1 for 1 cycle, ex_valid=0 that edge, ADD captured the following edge.
- Flush priority: flush=1 coincident with a load-use stall → stall_out=0, ex_valid=0, no extra bubble cycle.
- Immediates: instruction with imm8=8'h80 → ext=0 gives ex_imm8=16'hFF80, ext=1 gives 16'h0080. imm11=11'h400 → ex_imm11=16'hFC00. DATA_W=32 → upper bits sign-filled.
- SLBI path: asource=1 with r4=16'h00AB → ex_srca=16'hAB00. JAL destination → ex_wreg=7, ex_wen=1.
